// File: rtl/prog_delay_line_if.sv
// Sample/tap bus of the programmable delay line.
// The master drives the sample stream and tap select; the slave returns the delayed tap.
interface prog_delay_line_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
);
    logic             en;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             sel_chg;

    modport master (output en, sel, d, input q, q_valid, sel_chg);
    modport slave  (input en, sel, d, output q, q_valid, sel_chg);
endinterface

// File: rtl/prog_delay_line.sv
// Programmable delay line: MAX_DELAY-deep shift chain with a runtime-selected tap,
// fill tracking for output validity, and a pulse whenever the effective tap moves.
module prog_delay_line #(
    parameter int WIDTH     = 8,
    parameter int MAX_DELAY = 4,
    parameter int SEL_W     = $clog2(MAX_DELAY)
) (
    input logic              clk,
    input logic              reset,
    prog_delay_line_if.slave bus
);
    localparam int               FCW      = $clog2(MAX_DELAY + 1);
    localparam logic [SEL_W-1:0] MAX_TAP  = SEL_W'(MAX_DELAY - 1);
    localparam logic [FCW-1:0]   FULL_CNT = FCW'(MAX_DELAY);

    typedef enum logic [1:0] {EMPTY, FILL, FULL} fill_t;

    logic [MAX_DELAY-1:0][WIDTH-1:0] stage_q, stage_d;
    logic [SEL_W-1:0]                sel_q;
    logic [SEL_W-1:0]                eff_cur, eff_nxt;
    logic [FCW-1:0]                  fcnt_q, fcnt_d;
    logic                            sel_chg_q;
    fill_t                           state_q;

    // Clamping only exists when sel can encode taps beyond the chain.
    if ((1 << SEL_W) > MAX_DELAY) begin : g_clamp
        assign eff_cur = (sel_q > MAX_TAP)   ? MAX_TAP : sel_q;
        assign eff_nxt = (bus.sel > MAX_TAP) ? MAX_TAP : bus.sel;
    end else begin : g_noclamp
        assign eff_cur = sel_q;
        assign eff_nxt = bus.sel;
    end

    always_comb begin
        stage_d = stage_q;
        fcnt_d  = fcnt_q;
        if (bus.en) begin
            stage_d = {stage_q[MAX_DELAY-2:0], bus.d};
            if (fcnt_q != FULL_CNT) fcnt_d = fcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stage_q   <= '0;
            fcnt_q    <= '0;
            sel_q     <= '0;
            sel_chg_q <= 1'b0;
            state_q   <= EMPTY;
        end else begin
            stage_q   <= stage_d;
            fcnt_q    <= fcnt_d;
            sel_q     <= bus.sel;
            sel_chg_q <= (eff_nxt != eff_cur);
            if (bus.en) begin
                case (state_q)
                    EMPTY:   state_q <= FILL;
                    FILL:    if (fcnt_q == FULL_CNT - 1'b1) state_q <= FULL;
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    // A sample sits at tap eff once eff+1 enabled edges have filled the chain.
    assign bus.q       = stage_q[eff_cur];
    assign bus.q_valid = (state_q == FULL) || (fcnt_q > FCW'(eff_cur));
    assign bus.sel_chg = sel_chg_q;
endmodule

// File: tb/tb_prog_delay_line.sv
// Bench for prog_delay_line: default 8-bit/4-deep instance plus a 12-bit/6-deep clamping instance.
module tb_prog_delay_line;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    prog_delay_line_if #(.WIDTH(8),  .SEL_W(2)) ia();
    prog_delay_line_if #(.WIDTH(12), .SEL_W(3)) ib();

    prog_delay_line #(.WIDTH(8),  .MAX_DELAY(4)) dut_a (.clk(clk), .reset(rst_a), .bus(ia.slave));
    prog_delay_line #(.WIDTH(12), .MAX_DELAY(6)) dut_b (.clk(clk), .reset(rst_b), .bus(ib.slave));

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    // Model: history of enabled samples (newest first), samples loaded since reset, registered sel.
    int unsigned hq[2][$];
    int          mn[2];
    int          msel[2];
    bit          mchg[2];

    function automatic int clampsel(int k, int s);
        int m;
        m = (k == 0) ? 4 : 6;
        return (s > m - 1) ? m - 1 : s;
    endfunction

    function automatic void chk(string nm, int unsigned act, int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_edge(int k, bit rst, bit en, int sel, int unsigned d);
        if (!rst) begin
            hq[k].delete();
            mn[k]   = 0;
            msel[k] = 0;
            mchg[k] = 1'b0;
        end else begin
            mchg[k] = (clampsel(k, sel) != clampsel(k, msel[k]));
            msel[k] = sel;
            if (en) begin
                hq[k].push_front(d);
                if (hq[k].size() > 8) void'(hq[k].pop_back());
                if (mn[k] < 100) mn[k]++;
            end
        end
    endfunction

    function automatic int unsigned exp_q(int k);
        int e;
        e = clampsel(k, msel[k]);
        return (hq[k].size() > e) ? hq[k][e] : 0;
    endfunction

    function automatic int unsigned exp_v(int k);
        return (mn[k] > clampsel(k, msel[k])) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge(0, rst_a, ia.en, int'(ia.sel), int'(ia.d));
        model_edge(1, rst_b, ib.en, int'(ib.sel), int'(ib.d));
        chk_on = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_q",       ia.q,       exp_q(0));
            chk("a_q_valid", ia.q_valid, exp_v(0));
            chk("a_sel_chg", ia.sel_chg, mchg[0]);
            chk("b_q",       ib.q,       exp_q(1));
            chk("b_q_valid", ib.q_valid, exp_v(1));
            chk("b_sel_chg", ib.sel_chg, mchg[1]);
        end
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        ia.en = 1'b0; ia.sel = '0; ia.d = '0;
        ib.en = 1'b0; ib.sel = '0; ib.d = '0;
        tick();
        chk("rst_a_q", ia.q, 0);
        chk("rst_a_v", ia.q_valid, 0);
        chk("rst_b_q", ib.q, 0);
        chk("rst_b_v", ib.q_valid, 0);
        rst_a = 1'b1; rst_b = 1'b1;

        // eff=0: q follows d by one clock
        ia.en = 1'b1; ia.sel = 2'd0;
        for (int i = 3; i < 11; i++) begin
            ia.d = 8'(i);
            tick();
            chk("t1_q", ia.q, i);
            chk("t1_v", ia.q_valid, 1);
        end

        // sel=3: valid after 4th enabled edge, lag of 4
        rst_a = 1'b0; tick(); rst_a = 1'b1;
        ia.sel = 2'd3;
        for (int i = 0; i < 8; i++) begin
            ia.d = 8'(3 + i);
            tick();
            chk("t2_v", ia.q_valid, (i >= 3) ? 1 : 0);
            if (i >= 3) chk("t2_q", ia.q, i);
        end

        // en toggling with sel=1: delay counts enabled edges only
        rst_a = 1'b0; tick(); rst_a = 1'b1;
        ia.sel = 2'd1;
        ia.en = 1'b1; ia.d = 8'h10; tick(); chk("t3_v0", ia.q_valid, 0);
        ia.en = 1'b0; ia.d = 8'h55; tick(); chk("t3_v1", ia.q_valid, 0);
        ia.en = 1'b1; ia.d = 8'h11; tick(); chk("t3_q2", ia.q, 8'h10); chk("t3_v2", ia.q_valid, 1);
        ia.en = 1'b0; ia.d = 8'h66; tick(); chk("t3_q3", ia.q, 8'h10); chk("t3_v3", ia.q_valid, 1);
        ia.en = 1'b1; ia.d = 8'h12; tick(); chk("t3_q4", ia.q, 8'h11);

        // FULL, tap switch 0 -> 2 -> 0 on a running ramp
        rst_a = 1'b0; tick(); rst_a = 1'b1;
        ia.sel = 2'd0;
        for (int i = 0; i < 6; i++) begin
            ia.d = 8'(8'h20 + i);
            tick();
        end
        ia.sel = 2'd2; ia.d = 8'h26; tick();
        chk("t4_q_back", ia.q, 8'h24); chk("t4_chg1", ia.sel_chg, 1); chk("t4_v", ia.q_valid, 1);
        ia.d = 8'h27; tick();
        chk("t4_q_hold", ia.q, 8'h25); chk("t4_chg0", ia.sel_chg, 0);
        ia.sel = 2'd0; ia.d = 8'h28; tick();
        chk("t4_q_fwd", ia.q, 8'h28); chk("t4_chg2", ia.sel_chg, 1); chk("t4_v2", ia.q_valid, 1);
        ia.d = 8'h29; tick();
        chk("t4_chg3", ia.sel_chg, 0);

        // mid-ramp reset with sel=3
        ia.sel = 2'd3;
        for (int i = 0; i < 6; i++) begin
            ia.d = 8'(8'h30 + i);
            tick();
        end
        chk("t5_pre_v", ia.q_valid, 1);
        rst_a = 1'b0; ia.d = 8'h36; tick();
        chk("t5_rst_q", ia.q, 0); chk("t5_rst_v", ia.q_valid, 0);
        rst_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ia.d = 8'(8'h40 + i);
            tick();
            chk("t5_v", ia.q_valid, (i >= 3) ? 1 : 0);
            if (i == 3) chk("t5_q", ia.q, 8'h40);
        end
        ia.en = 1'b0;

        // 6-deep, 12-bit: sel=7 clamps to eff=5
        ib.sel = 3'd7; ib.en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ib.d = 12'(12'hABC + i);
            tick();
            if (i == 0) chk("t6_chg_first", ib.sel_chg, 1);
            chk("t6_v", ib.q_valid, (i >= 5) ? 1 : 0);
            if (i >= 5) chk("t6_q", ib.q, 12'hABC + i - 5);
        end
        ib.sel = 3'd6; ib.d = 12'hAC4; tick();
        chk("t6_no_chg", ib.sel_chg, 0); chk("t6_q_clamp", ib.q, 12'hABF);
        ib.sel = 3'd4; ib.d = 12'hAC5; tick();
        chk("t6_chg", ib.sel_chg, 1); chk("t6_q_tap4", ib.q, 12'hAC1);
        rst_b = 1'b0; tick();
        chk("t6_rst_q", ib.q, 0); chk("t6_rst_v", ib.q_valid, 0);
        rst_b = 1'b1; ib.en = 1'b0;
        tick();

        chk_on = 1'b0;
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prog_delay_line.md
# prog_delay_line

Parametrised programmable delay line. Each enabled clock edge shifts a WIDTH-bit sample into a MAX_DELAY-deep register chain. The output tap is selected at runtime, giving a delay of sel+1 enabled cycles. It generalises the fixed 8-bit, 4-setting selectable delay used in the homework datapaths, adding configurable width and depth, clock enable, fill tracking with an output-valid flag, and out-of-range select clamping.

## Interface
- WIDTH, 8, data width in bits (>=1)
- MAX_DELAY, 4, number of register stages; the maximum delay in enabled cycles (>=2)
- SEL_W, $clog2(MAX_DELAY), width of sel
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  reset, synchronous, active-low
- en  input  1  shift enable; the chain advances only on edges where en=1
- sel  input  SEL_W  requested delay minus one
- d  input  WIDTH  sample in
- q  output  WIDTH  delayed sample
- q_valid  output  1  1 when q holds a sample actually loaded since reset
- sel_chg  output  1  one-cycle pulse when the effective tap changes

## Operation
- Storage: stage[0..MAX_DELAY-1]. On an edge with en=1: stage[0]<=d and stage[i]<=stage[i-1].
- Tap select:
  - sel is registered into sel_r on every edge, regardless of en.
  - Effective tap: eff = min(sel_r, MAX_DELAY-1). Out-of-range sel values clamp to the deepest tap.
- Output: q = stage[eff], a combinational mux from registers only. Delay is eff+1 enabled edges.
- Fill counter fcnt, range 0..MAX_DELAY:
  - Increments on each edge with en=1.
  - Saturates at MAX_DELAY.
  - Cleared only by reset.
- Fill state, derived from fcnt:
  - EMPTY (fcnt=0) -> FILL on the first en edge.
  - FILL -> FULL when fcnt reaches MAX_DELAY.
  - FULL is held until reset.
- q_valid = (fcnt >= eff+1). Changing sel never invalidates stored data. A deeper tap may drop q_valid during FILL.
- sel_chg: registered; equals 1 for the cycle after any edge where the new eff differs from the previous eff.
- Arithmetic: fcnt width is $clog2(MAX_DELAY+1). The eff comparison is unsigned. No data arithmetic is performed; samples pass bit-exact.

## Timing
- Reset (reset=0 at an edge):
  - All stages = 0, fcnt = 0, sel_r = 0, sel_chg = 0.
  - Hence q = 0 and q_valid = 0 from the following cycle.
  - Reset overrides en and sel.
- Latency: d sampled at enabled edge k appears on q after enabled edge k+eff, when eff is constant.
- With en held high and eff=0, q follows d by exactly one clock.
- en=0 edges:
  - Stages and fcnt hold.
  - q still changes if sel_r changes.
- Select change:
  - sel applied before edge k updates sel_r at edge k.
  - q switches tap after edge k, combined with any shift on that same edge.
  - sel_chg is high in the cycle after edge k.
- Simultaneous sel change and en=1: both the shift and the tap switch take effect on the same edge. q shows the new tap of the shifted chain.
- Reset mid-operation: all history is discarded. The delay restarts from EMPTY, with q_valid low until eff+1 further enabled edges.
- Saturation: fcnt stops at MAX_DELAY. There is no wrap-around, so q_valid never falls except on reset or a tap increase during FILL.

## Test plan
- Reset, then d=3,4,5,... every cycle with en=1 and sel=0 (default params).
  - Expected: q=0 and q_valid=0 after reset.
  - Expected: after each edge, q equals the previous cycle's d (3,4,5,...), and q_valid=1 from the first edge.
- Same ramp with sel=3.
  - Expected: q_valid rises after the 4th enabled edge, with q=3.
  - Expected: q then lags d by 4 cycles.
- Ramp from 0x10 with sel=1, en toggling 1,0,1,0.
  - Expected: q and q_valid hold on en=0 cycles.
  - Expected: delay counts enabled edges only; the 2nd enabled sample 0x11 appears after the 3rd enabled edge.
- In FULL with sel=0, switch sel to 2 and back on a running ramp.
  - Expected: q jumps back 2 samples, then forward 2.
  - Expected: sel_chg pulses one cycle after each switch.
  - Expected: q_valid stays 1.
- reset=0 for one edge mid-ramp with sel=3.
  - Expected: q=0 and q_valid=0 next cycle.
  - Expected: q_valid returns after exactly 4 enabled edges.
- MAX_DELAY=6, WIDTH=12, sel=7.
  - Expected: clamps to eff=5, giving a delay of 6.
  - Expected: changing sel from 7 to 6 gives no sel_chg pulse, because eff is unchanged.
  - Expected: 12-bit samples such as 0xABC pass unmodified.
